// File: rtl/p21_game_ctrl.sv
// Dino game-flow controller: IDLE/RUN/DEAD FSM, pixel collision, speed ramp and score.
// All outputs registered; one cycle from input sample to output, no backpressure.
module p21_game_ctrl #(
    parameter logic [23:0] SPEED_INIT   = 24'd200000,
    parameter logic [23:0] SPEED_MIN    = 24'd80000,
    parameter logic [23:0] SPEED_STEP   = 24'd2000,
    parameter logic [7:0]  RAMP_FRAMES  = 8'd240,
    parameter logic [3:0]  SCORE_FRAMES = 4'd6,
    parameter logic [5:0]  DEAD_FRAMES  = 6'd30
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        button,
    input  logic        frame_start,
    input  logic        dino_px,
    input  logic        obs_px,
    output logic        jump,
    output logic        halt,
    output logic        game_rst,
    output logic [23:0] speed,
    output logic [13:0] score
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam logic [13:0] SCORE_MAX = 14'd9999;

    state_t      state_q, state_d;
    logic        button_q, armed_q, armed_d;
    logic        jump_q, jump_d;
    logic        halt_q, halt_d;
    logic        game_rst_q, game_rst_d;
    logic [23:0] speed_q, speed_d;
    logic [13:0] score_q, score_d;
    logic [5:0]  holdoff_q, holdoff_d;
    logic [7:0]  ramp_cnt_q, ramp_cnt_d;
    logic [3:0]  score_cnt_q, score_cnt_d;

    logic        press, collide, frame_tick, start;
    logic [24:0] speed_dec;

    always_comb begin
        // armed_q blocks a button held through reset from counting as a press
        press      = button & ~button_q & armed_q;
        collide    = (state_q == S_RUN) & ~game_rst_q & dino_px & obs_px;
        frame_tick = frame_start & (state_q == S_RUN) & ~game_rst_q;
        speed_dec  = {1'b0, speed_q} - {1'b0, SPEED_STEP};

        state_d     = state_q;
        start       = 1'b0;
        holdoff_d   = holdoff_q;
        armed_d     = armed_q | ~button;
        speed_d     = speed_q;
        score_d     = score_q;
        ramp_cnt_d  = ramp_cnt_q;
        score_cnt_d = score_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d = S_RUN;
                    start   = 1'b1;
                end
            end
            S_RUN: begin
                if (collide) begin
                    state_d   = S_DEAD;
                    holdoff_d = DEAD_FRAMES;
                end
            end
            S_DEAD: begin
                if (frame_start && holdoff_q != 6'd0) begin
                    holdoff_d = holdoff_q - 6'd1;
                end
                if (press && holdoff_q == 6'd0) begin
                    state_d = S_RUN;
                    start   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_tick) begin
            if (score_cnt_q == SCORE_FRAMES - 4'd1) begin
                score_cnt_d = 4'd0;
                if (score_q != SCORE_MAX) begin
                    score_d = score_q + 14'd1;
                end
            end else begin
                score_cnt_d = score_cnt_q + 4'd1;
            end

            if (ramp_cnt_q == RAMP_FRAMES - 8'd1) begin
                ramp_cnt_d = 8'd0;
                if (speed_dec[24] || speed_dec[23:0] < SPEED_MIN) begin
                    speed_d = SPEED_MIN;
                end else begin
                    speed_d = speed_dec[23:0];
                end
            end else begin
                ramp_cnt_d = ramp_cnt_q + 8'd1;
            end
        end

        if (start) begin
            speed_d     = SPEED_INIT;
            score_d     = 14'd0;
            ramp_cnt_d  = 8'd0;
            score_cnt_d = 4'd0;
        end

        game_rst_d = start;
        halt_d     = (state_d != S_RUN);
        jump_d     = (state_d == S_RUN) & button & ~collide & ~start;
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            button_q    <= 1'b0;
            armed_q     <= 1'b0;
            jump_q      <= 1'b0;
            halt_q      <= 1'b1;
            game_rst_q  <= 1'b0;
            speed_q     <= SPEED_INIT;
            score_q     <= 14'd0;
            holdoff_q   <= 6'd0;
            ramp_cnt_q  <= 8'd0;
            score_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            button_q    <= button;
            armed_q     <= armed_d;
            jump_q      <= jump_d;
            halt_q      <= halt_d;
            game_rst_q  <= game_rst_d;
            speed_q     <= speed_d;
            score_q     <= score_d;
            holdoff_q   <= holdoff_d;
            ramp_cnt_q  <= ramp_cnt_d;
            score_cnt_q <= score_cnt_d;
        end
    end

    assign jump     = jump_q;
    assign halt     = halt_q;
    assign game_rst = game_rst_q;
    assign speed    = speed_q;
    assign score    = score_q;

endmodule

// File: tb/tb_p21_game_ctrl.sv
// Bench for p21_game_ctrl: directed vector table plus hand-written DEAD/holdoff/reset sequences.
module tb_p21_game_ctrl;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        button, frame_start, dino_px, obs_px;
    logic        jump, halt, game_rst;
    logic [23:0] speed;
    logic [13:0] score;
    logic        s_jump, s_halt, s_game_rst;
    logic [23:0] s_speed;
    logic [13:0] s_score;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Small-parameter instance for ramp/score/holdoff behaviour
    p21_game_ctrl #(
        .SPEED_INIT(24'd10), .SPEED_MIN(24'd3), .SPEED_STEP(24'd4),
        .RAMP_FRAMES(8'd4), .SCORE_FRAMES(4'd6), .DEAD_FRAMES(6'd30)
    ) u_dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .button(button), .frame_start(frame_start),
        .dino_px(dino_px), .obs_px(obs_px), .jump(jump), .halt(halt),
        .game_rst(game_rst), .speed(speed), .score(score)
    );

    // Default speeds with one frame per point, used for the saturation run
    p21_game_ctrl #(
        .SCORE_FRAMES(4'd1)
    ) u_sat (
        .clk(clk), .sys_rst_n(sys_rst_n), .button(button), .frame_start(frame_start),
        .dino_px(dino_px), .obs_px(obs_px), .jump(s_jump), .halt(s_halt),
        .game_rst(s_game_rst), .speed(s_speed), .score(s_score)
    );

    typedef struct {
        logic b, f, d, o;
        logic halt, jump, grst;
        int   score;
        int   speed;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic b, input logic f, input logic d, input logic o,
                        input logic h, input logic j, input logic g,
                        input int sc, input int sp);
        vec_t v;
        v.b = b; v.f = f; v.d = d; v.o = o;
        v.halt = h; v.jump = j; v.grst = g; v.score = sc; v.speed = sp;
        tbl.push_back(v);
    endtask

    task automatic cyc(input logic b, input logic f, input logic d, input logic o);
        button = b; frame_start = f; dino_px = d; obs_px = o;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic h, input logic j, input logic g,
                           input int sc, input int sp);
        chk({nm, ".halt"},     32'(halt), 32'(h));
        chk({nm, ".jump"},     32'(jump), 32'(j));
        chk({nm, ".game_rst"}, 32'(game_rst), 32'(g));
        chk({nm, ".score"},    32'(score), sc);
        chk({nm, ".speed"},    32'(speed), sp);
    endtask

    initial begin
        int sp_seq[16] = '{10, 10, 10, 6, 6, 6, 6, 3, 3, 3, 3, 3, 3, 3, 3, 3};

        // Button held through reset, then 5 cycles held: must stay idle
        for (int i = 0; i < 5; i++) addv(1, 0, 0, 0, 1, 0, 0, 0, 10);
        addv(0, 0, 0, 0, 1, 0, 0, 0, 10);
        addv(1, 0, 0, 0, 0, 0, 1, 0, 10);   // press: game_rst, halt falls
        addv(1, 0, 0, 0, 0, 1, 0, 0, 10);   // jump follows
        for (int k = 1; k <= 16; k++) addv(0, 1, 0, 0, 0, 0, 0, k / 6, sp_seq[k-1]);
        addv(1, 0, 1, 0, 0, 1, 0, 2, 3);    // dino alone: no collision
        addv(1, 0, 0, 1, 0, 1, 0, 2, 3);    // obstacle alone
        addv(1, 0, 1, 1, 1, 0, 0, 2, 3);    // collision with button held
        for (int i = 0; i < 10; i++) addv(1, 1, 0, 0, 1, 0, 0, 2, 3);

        sys_rst_n = 1'b0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_out("reset", 1, 0, 0, 0, 10);
        chk("reset.sat_speed", 32'(s_speed), 200000);
        sys_rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].b, tbl[i].f, tbl[i].d, tbl[i].o);
            chk_out($sformatf("vec%0d", i), tbl[i].halt, tbl[i].jump, tbl[i].grst,
                    tbl[i].score, tbl[i].speed);
        end

        // Holdoff now 20: early presses ignored until it reaches 0
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_out("dead_press_early", 1, 0, 0, 2, 3);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 19; i++) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk_out("dead_press_hold1", 1, 0, 0, 2, 3);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk_out("restart", 0, 0, 1, 0, 10);
        cyc(1, 0, 0, 0);
        chk_out("restart_next", 0, 1, 0, 0, 10);

        // Collision, press and frame in one cycle
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
        chk_out("pre_simul", 0, 0, 0, 0, 6);
        cyc(1, 1, 1, 1);
        chk_out("simul", 1, 0, 0, 1, 6);
        cyc(1, 1, 0, 0);
        chk_out("simul_frozen", 1, 0, 0, 1, 6);

        // Back to RUN, then reset mid-game
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk_out("restart2", 0, 0, 1, 0, 10);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
        chk_out("run2", 0, 0, 0, 1, 6);
        sys_rst_n = 1'b0;
        cyc(1, 1, 1, 1);
        chk_out("midrun_reset", 1, 0, 0, 0, 10);
        chk("midrun_reset.sat_speed", 32'(s_speed), 200000);
        sys_rst_n = 1'b1;

        // Score saturation on the one-frame-per-point instance
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("sat_start.game_rst", 32'(s_game_rst), 1);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 9998; i++) cyc(0, 1, 0, 0);
        chk("sat.score_9998", 32'(s_score), 9998);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
        chk("sat.score_9999", 32'(s_score), 9999);
        chk("sat.speed", 32'(s_speed), 118000);
        chk("sat.dut_score", 32'(score), 1667);
        chk("sat.dut_speed", 32'(speed), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p21_game_ctrl.md
# p21_game_ctrl

Game-flow controller for the dino game, sitting directly upstream of the jump-physics block. It supplies that block's `jump`, `halt`, `speed` and `game_rst` inputs. It runs the IDLE/RUN/DEAD state machine, detects dino–obstacle pixel overlap during the video scan, ramps difficulty by shortening the jump-frame divisor, and keeps the score.

## Interface

Parameters:
- `SPEED_INIT`, 24'd200000: `speed` value after reset and after each restart.
- `SPEED_MIN`, 24'd80000: floor for `speed`.
- `SPEED_STEP`, 24'd2000: amount `speed` decreases per ramp event.
- `RAMP_FRAMES`, 8'd240: RUN frames between ramp events (≥1).
- `SCORE_FRAMES`, 4'd6: RUN frames per score point (≥1).
- `DEAD_FRAMES`, 6'd30: frames for which presses are ignored after death.

Ports:
- `clk` in 1: single system clock.
- `sys_rst_n` in 1: synchronous, active-low reset.
- `button` in 1: debounced jump/start button, level, synchronous to `clk`.
- `frame_start` in 1: one-cycle pulse at the start of each video frame.
- `dino_px` in 1: dino sprite covers the current scan pixel.
- `obs_px` in 1: obstacle covers the current scan pixel.
- `jump` out 1: jump request to the physics block.
- `halt` out 1: freezes physics and obstacles.
- `game_rst` out 1: one-cycle pulse clearing game-side blocks.
- `speed` out 24: physics frame-step divisor.
- `score` out 14: binary score, saturating at 9999.

## Operation

- The button edge detector registers `button` into `button_q`. `press` = `button & ~button_q`.
- `collide` = `dino_px & obs_px`. It is evaluated only in RUN and only when `game_rst` is 0.
- **IDLE** (entered on reset): `halt`=1.
  - `press` → RUN, with a `game_rst` pulse.
- **RUN**: `halt`=0.
  - `collide` → DEAD. The holdoff counter loads `DEAD_FRAMES`.
  - Collision wins over a simultaneous `press`.
- **DEAD**: `halt`=1. `score` and `speed` are frozen.
  - The holdoff counter decrements on each `frame_start` and stops at 0.
  - `press` while the holdoff is nonzero is ignored.
  - `press` with the holdoff at 0 → RUN, with a `game_rst` pulse.
- **Restart/start action** (same cycle as the transition into RUN):
  - `game_rst`=1, `speed`=`SPEED_INIT`, `score`=0.
  - The ramp and score frame counters clear.
- **Frame counters**: they advance only on `frame_start` cycles where the state is RUN and `game_rst`=0. This includes the collision cycle.
  - Score counter wraps at `SCORE_FRAMES`-1. On wrap, `score` += 1, saturating at 9999.
  - Ramp counter wraps at `RAMP_FRAMES`-1. On wrap, `speed` = max(`speed` − `SPEED_STEP`, `SPEED_MIN`).
  - Compute the subtraction in 25 bits so it cannot underflow.
- **`jump`** = registered (state==RUN & `button` & ~`collide` & ~`game_rst`). It is a level; the physics block ignores it while airborne.

## Timing

- All outputs are registered. Reset values: state IDLE, `halt`=1, `jump`=0, `game_rst`=0, `speed`=`SPEED_INIT`, `score`=0, holdoff=0, `button_q`=0.
- Reset has priority over every other event, including mid-game. After reset, a held button needs release and re-press to start.
- `press` sampled at edge N gives, at edge N+1: `game_rst`=1, `halt`=0, state RUN.
  - At edge N+2: `game_rst`=0.
  - `jump` is first able to be 1 at edge N+2.
- `collide` sampled at edge N gives `halt`=1 and `jump`=0 at edge N+1. Latency is 1 cycle.
- A `frame_start` pulse sampled at edge N updates `score` and `speed` at edge N+1.
- `game_rst` is never longer than one cycle.
- A button held through death never restarts the game; it needs a new rising edge.

## Test plan

- **Reset and start:** reset, then hold `button` high for 5 cycles → `halt`=1, `speed`=200000, `score`=0.
  - Then release and press → one-cycle `game_rst`, `halt` falls on the same edge, `jump` high the following edge.
- **Scoring:** in RUN, 12 `frame_start` pulses with `SCORE_FRAMES`=6 → `score`=2.
  - Preload via 9999×6 frames (or force) → `score` stays 9999.
- **Speed ramp:** with `RAMP_FRAMES`=4, `SPEED_INIT`=10, `SPEED_STEP`=4, `SPEED_MIN`=3, run 16 frames → `speed` sequence 6, 3, 3, 3.
- **Collision:** `dino_px`=`obs_px`=1 for one cycle while `button`=1 → next edge `halt`=1, `jump`=0.
  - Then 10 frames → `score`/`speed` unchanged.
- **Holdoff:** after death with `DEAD_FRAMES`=30, press at frame 5 → ignored.
  - Press at frame 31 → `game_rst` pulse, `score`=0, `speed`=`SPEED_INIT`.
- **Simultaneous events and reset:** `collide`, `press` and `frame_start` in one RUN cycle → DEAD, counters advance once, no `game_rst`.
  - Assert `sys_rst_n`=0 mid-RUN → all outputs return to reset values on the next edge.
